// File: rtl/slow_to_fast_sync.sv
// slow_to_fast_sync: carries a slow-domain level into the clkb domain through a flop chain and
// emits one-cycle rise/fall strobes. Define SYNC_FILTER_EN to add a FILTER_LEN-cycle glitch filter.
`timescale 1ns/100ps
module slow_to_fast_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic clkb,
    input  logic rst,
    input  logic signal_a,
    output logic singal_b,
    output logic rise_b,
    output logic fall_b
);

    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
            $error("slow_to_fast_sync: SYNC_STAGES must be in 2..4");
        end
        if (FILTER_LEN < 2 || FILTER_LEN > 15) begin : g_bad_filter
            $error("slow_to_fast_sync: FILTER_LEN must be in 2..15");
        end
    endgenerate

    // sync_q[0] is the only flop allowed to go metastable; only sync_q[1] reads it.
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   level_b;
    logic                   prev_q;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], signal_a};
    end

    always_ff @(posedge clkb) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

`ifdef SYNC_FILTER_EN
    localparam int CNT_W = $clog2(FILTER_LEN);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             filt_q;
    logic             filt_d;

    // Count consecutive cycles where the synchronized value disagrees with the output;
    // any agreeing cycle restarts the count.
    always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        if (sync_q[SYNC_STAGES-1] != filt_q) begin
            if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
                filt_d = sync_q[SYNC_STAGES-1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clkb) begin
        if (rst) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign level_b = filt_q;
`else
    assign level_b = sync_q[SYNC_STAGES-1];
`endif

    always_ff @(posedge clkb) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level_b;
        end
    end

    // Strobes are decoded from two flops only, so they never glitch and never overlap.
    assign singal_b = level_b;
    assign rise_b   = level_b & ~prev_q;
    assign fall_b   = ~level_b & prev_q;

endmodule

// File: tb/tb_slow_to_fast_sync.sv
// Bench for slow_to_fast_sync: a vector table, hand-written corner sequences and random stimulus
// checked against a per-edge reference model, on a 2-stage and a 3-stage instance.
`timescale 1ns/100ps
module tb_slow_to_fast_sync;

`ifdef SYNC_FILTER_EN
    localparam int FLT = 3;
`else
    localparam int FLT = 0;
`endif

    logic clkb = 1'b0;
    logic rst;
    logic signal_a;
    logic b2, r2, f2;
    logic b3, r3, f3;

    int n_cmp = 0;
    int n_err = 0;

    slow_to_fast_sync #(.SYNC_STAGES(2), .FILTER_LEN(3)) dut2 (
        .clkb(clkb), .rst(rst), .signal_a(signal_a),
        .singal_b(b2), .rise_b(r2), .fall_b(f2)
    );

    slow_to_fast_sync #(.SYNC_STAGES(3), .FILTER_LEN(3)) dut3 (
        .clkb(clkb), .rst(rst), .signal_a(signal_a),
        .singal_b(b3), .rise_b(r3), .fall_b(f3)
    );

    always #3 clkb = ~clkb;

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got {b,rise,fall}=%b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, act, lo, hi, $time);
        end
    endtask

    // Input history as seen at every rising edge; the model reads it back by edge number.
    bit a_hist[$];
    bit r_hist[$];
    int first_rst = -1;

    bit win_on = 1'b0;
    int w_rise, w_fall, w_high, w_first_a, w_first_rise;

    always @(posedge clkb) begin
        a_hist.push_back(signal_a);
        r_hist.push_back(rst);
        if (rst && first_rst < 0) first_rst = a_hist.size() - 1;
        if (win_on && signal_a && w_first_a < 0) w_first_a = a_hist.size() - 1;
    end

    // Chain output after edge n: the input sampled s-1 edges earlier, zero if a reset hit the window.
    function automatic bit lev(int n, int s);
        if (n - s + 1 < first_rst) return 1'b0;
        for (int j = n - s + 1; j <= n; j++) begin
            if (r_hist[j]) return 1'b0;
        end
        return a_hist[n - s + 1];
    endfunction

    function automatic bit next_level(int n, int s, bit prev_lvl);
`ifdef SYNC_FILTER_EN
        if (r_hist[n]) return 1'b0;
        if (n - FLT < first_rst) return prev_lvl;
        for (int k = 1; k <= FLT; k++) begin
            if (lev(n - k, s) == prev_lvl) return prev_lvl;
        end
        return ~prev_lvl;
`else
        return (prev_lvl & 1'b0) | lev(n, s);
`endif
    endfunction

    logic [2:0] exp2_q[$];
    logic [2:0] exp3_q[$];
    bit lvl2 = 1'b0;
    bit lvl3 = 1'b0;

    always @(negedge clkb) begin
        int n;
        bit l2n, l3n, p2, p3;
        n = a_hist.size() - 1;
        if (first_rst >= 0 && n >= first_rst) begin
            l2n = next_level(n, 2, lvl2);
            l3n = next_level(n, 3, lvl3);
            p2 = r_hist[n] ? 1'b0 : lvl2;
            p3 = r_hist[n] ? 1'b0 : lvl3;
            exp2_q.push_back({l2n, l2n & ~p2, ~l2n & p2});
            exp3_q.push_back({l3n, l3n & ~p3, ~l3n & p3});
            lvl2 = l2n;
            lvl3 = l3n;
            check("model_s2", {b2, r2, f2}, exp2_q.pop_front());
            check("model_s3", {b3, r3, f3}, exp3_q.pop_front());
        end
        if (win_on) begin
            w_rise += int'(r2);
            w_fall += int'(f2);
            w_high += int'(b2);
            if (r2 && w_first_rise < 0) w_first_rise = n;
        end
    end

    task automatic win_start();
        w_rise = 0; w_fall = 0; w_high = 0;
        w_first_a = -1; w_first_rise = -1;
        win_on = 1'b1;
    endtask

`ifndef SYNC_FILTER_EN
    typedef struct {
        bit         rst;
        bit         a;
        logic [2:0] exp;
    } vec_t;

    task automatic run_table();
        vec_t vecs[15];
        vecs[0]  = '{1'b1, 1'b1, 3'b000};
        vecs[1]  = '{1'b1, 1'b1, 3'b000};
        vecs[2]  = '{1'b0, 1'b1, 3'b000};
        vecs[3]  = '{1'b0, 1'b1, 3'b110};
        vecs[4]  = '{1'b0, 1'b1, 3'b100};
        vecs[5]  = '{1'b0, 1'b0, 3'b100};
        vecs[6]  = '{1'b0, 1'b0, 3'b001};
        vecs[7]  = '{1'b0, 1'b0, 3'b000};
        vecs[8]  = '{1'b0, 1'b1, 3'b000};
        vecs[9]  = '{1'b0, 1'b0, 3'b110};
        vecs[10] = '{1'b0, 1'b1, 3'b001};
        vecs[11] = '{1'b0, 1'b0, 3'b110};
        vecs[12] = '{1'b1, 1'b0, 3'b000};
        vecs[13] = '{1'b0, 1'b0, 3'b000};
        vecs[14] = '{1'b0, 1'b0, 3'b000};
        for (int i = 0; i < 15; i++) begin
            rst      = vecs[i].rst;
            signal_a = vecs[i].a;
            @(negedge clkb);
            check($sformatf("table_row%0d", i), {b2, r2, f2}, vecs[i].exp);
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish by %0t", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        signal_a = 1'b1;
`ifndef SYNC_FILTER_EN
        run_table();
`else
        repeat (2) @(negedge clkb);
        check("reset_state", {b2, r2, f2}, 3'b000);
`endif

        // Three-stage step, launched just ahead of a clkb edge.
        rst = 1'b0;
        signal_a = 1'b0;
        repeat (8 + FLT) @(negedge clkb);
        signal_a = 1'b1;
        for (int e = 1; e <= 5 + FLT; e++) begin
            @(negedge clkb);
            check($sformatf("s3_step_e%0d", e), {b3, r3, f3}, {e >= 3 + FLT, e == 3 + FLT, 1'b0});
        end

        // Reset while the output is high: everything clears, no fall strobe.
        for (int i = 0; i < 20 && !b2; i++) @(negedge clkb);
        check("midrst_pre", {b2, 2'b00}, 3'b100);
        rst = 1'b1;
        @(negedge clkb);
        check("midrst_s2", {b2, r2, f2}, 3'b000);
        check("midrst_s3", {b3, r3, f3}, 3'b000);
        @(negedge clkb);
        rst = 1'b0;
        for (int e = 1; e <= 5 + FLT; e++) begin
            @(negedge clkb);
            check($sformatf("release_e%0d", e), {b2, r2, f2}, {e >= 2 + FLT, e == 2 + FLT, 1'b0});
        end

        // Slow-domain pulses at an unrelated phase: 20 ns high, 200 ns low.
        signal_a = 1'b0;
        repeat (10 + FLT) @(negedge clkb);
        #1.5;
        for (int p = 0; p < 10; p++) begin
            win_start();
            signal_a = 1'b1;
            #20;
            signal_a = 1'b0;
            #200;
            win_on = 1'b0;
            check_range($sformatf("pulse%0d_rise_cnt", p), w_rise, 1, 1);
            check_range($sformatf("pulse%0d_fall_cnt", p), w_fall, 1, 1);
            check_range($sformatf("pulse%0d_high_cycles", p), w_high, 3, 4);
            check_range($sformatf("pulse%0d_rise_latency", p),
                        w_first_rise - w_first_a + 1, 2 + FLT, 3 + FLT);
        end

        // Idle input for 1000 ns.
        win_start();
        #1000;
        win_on = 1'b0;
        check_range("idle_activity", w_rise + w_fall + w_high, 0, 0);

        // Random levels, holds and occasional resets against the model.
        @(negedge clkb);
        for (int s = 0; s < 400; s++) begin
            rst      = ($urandom_range(0, 29) == 0);
            signal_a = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 8)) @(negedge clkb);
        end
        rst = 1'b0;
        repeat (6 + FLT) @(negedge clkb);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/slow_to_fast_sync.md
Name: slow_to_fast_sync

Overview:
- Synchronizes a single-bit signal from a slow clock domain into a fast clock domain.
- signal_a is treated as fully asynchronous to clkb. It passes through a multi-flop synchronizer chain clocked by clkb.
- Outputs: the synchronized level plus one-cycle rise/fall strobes.
- Sits at the boundary of the fast (clkb) domain. It is the only place signal_a may enter clkb logic.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops (legal 2..4); sets level latency.
- FILTER_LEN, 3, consecutive clkb samples required before a level change is accepted (used only with SYNC_FILTER_EN; legal 2..15).

Ports:
- clkb  input  1  fast destination clock; every flop is on its rising edge.
- rst  input  1  synchronous reset, active-high, sampled on clkb rising edge.
- signal_a  input  1  asynchronous level/pulse from the slow domain. It must stay stable ≥ 2 clkb periods to be guaranteed seen.
- singal_b  output  1  synchronized level of signal_a in the clkb domain.
- rise_b  output  1  one-clkb-cycle strobe when singal_b goes 0->1.
- fall_b  output  1  one-clkb-cycle strobe when singal_b goes 1->0.

Behaviour:
- Reset: with rst=1 at a clkb rising edge, all synchronizer stages, the history flop and the filter state clear to 0. singal_b=0, rise_b=0, fall_b=0 from the next edge on.
- rst has priority over all other activity. Reset mid-transfer discards any in-flight value.
- Synchronizer: sync[0] <= signal_a; sync[i] <= sync[i-1]; singal_b = sync[SYNC_STAGES-1].
  - Only sync[0] may go metastable. No logic other than sync[1] reads sync[0].
- Latency: a signal_a change meeting setup before clkb edge k appears on singal_b after edge k+SYNC_STAGES-1. That is SYNC_STAGES edges counting edge k.
  - Default: 2 edges; add up to 1 cycle of uncertainty for asynchronous sampling.
- Pulse width: an input high for N clkb edges yields singal_b high for N cycles (±1 due to sampling). An input shorter than one clkb period may be lost; this is permitted.
- History flop: prev_b <= singal_b every edge.
  - rise_b = singal_b & ~prev_b.
  - fall_b = ~singal_b & prev_b.
  - Both derive from registered signals only.
  - Each strobe is high exactly one cycle per transition, and both are never high together.
- Back-to-back transitions: every transition of singal_b produces exactly one strobe. There is no merging or dropping inside the block.
- The first cycle after reset deasserts with signal_a already high produces a rise_b after the normal latency.
- No handshake; open-loop transfer.

Optional Feature:
- Macro SYNC_FILTER_EN.
- When defined: a counter after sync[SYNC_STAGES-1] feeds singal_b.
  - singal_b changes only after the synchronized value differs from singal_b for FILTER_LEN consecutive clkb cycles.
  - Any mismatch gap resets the count.
  - Added latency = FILTER_LEN cycles.
  - Synchronized pulses shorter than FILTER_LEN cycles are suppressed entirely; no strobe is produced.
- When undefined: no counter; singal_b = sync[SYNC_STAGES-1] directly, with latency as above.

Test Plan:
- Reset: rst=1 for 2 clkb cycles with signal_a=1 -> singal_b/rise_b/fall_b all 0. Release rst -> singal_b=1 after 2 edges, with one rise_b pulse.
- Slow pulse: clka 20 ns, clkb 6 ns; signal_a high 20 ns then low 200 ns, 10 repeats -> each high pulse gives singal_b high 3–4 cycles, exactly one rise_b and one fall_b, and first rise ≤ 3 clkb edges after signal_a rises.
- Idle: signal_a held 0 for 1000 ns -> singal_b, rise_b and fall_b remain 0.
- SYNC_STAGES=3: step signal_a 0->1 aligned just before a clkb edge -> singal_b rises on the 3rd edge; the strobe is 1 cycle.
- Mid-operation reset: assert rst while singal_b=1 -> all outputs 0 next edge, and no fall_b emitted.
- With SYNC_FILTER_EN, FILTER_LEN=3: a 1-cycle glitch on signal_a -> no change on singal_b. A 20 ns pulse (≥3 cycles) -> singal_b rises 3 cycles later than without the macro.
